seg7_scan_driver: RTL and testbench

- Time-multiplexed, common-anode seven-segment display driver for the calculator front panel.
- It is the output-side counterpart of the switch debouncer. The debouncer conditions human input; this block drives human-visible output.
- Uses the same free-running tick-counter style as the debouncer.
- Accepts a packed hex word via a load strobe and applies it only at frame boundaries, so a display update never tears mid-frame.
- Scans one digit per slot and inserts a blanking interval at the start of each slot to suppress ghosting.

---
 rtl/seg7_scan_driver.sv | 158 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner. Display data is double-
// buffered (pending -> shadow) and swapped only at frame end, so frames never tear.
module seg7_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int TICK_COUNT   = 100000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     en_in,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int QW = $clog2(TICK_COUNT);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [QW-1:0] Q_LAST   = QW'(TICK_COUNT - 1);
  localparam logic [QW-1:0] Q_LIT    = QW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  logic [QW-1:0]       q_q, q_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d, pd_data_q, pd_data_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, pd_dp_q, pd_dp_d;
  logic [DIGITS-1:0]   sh_en_q, sh_en_d, pd_en_q, pd_en_d;
  logic                pend_valid_q, pend_valid_d;
  logic                started_q, started_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d, fs_q, fs_d;

  logic                slot_end, frame_end;
  logic [3:0]          nib;
  logic                en_bit, dp_bit;

  assign slot_end  = (q_q == Q_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  // Counter and double-buffer next state.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    q_d          = q_q + QW'(1);
    idx_d        = idx_q;
    sh_data_d    = sh_data_q;
    sh_dp_d      = sh_dp_q;
    sh_en_d      = sh_en_q;
    pd_data_d    = pd_data_q;
    pd_dp_d      = pd_dp_q;
    pd_en_d      = pd_en_q;
    pend_valid_d = pend_valid_q;
    started_d    = started_q | frame_end;
    if (slot_end) begin
      q_d   = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    if (load && frame_end) begin
      sh_data_d    = data_in;
      sh_dp_d      = dp_in;
      sh_en_d      = en_in;
      pend_valid_d = 1'b0;
    end else if (frame_end && pend_valid_q) begin
      sh_data_d    = pd_data_q;
      sh_dp_d      = pd_dp_q;
      sh_en_d      = pd_en_q;
      pend_valid_d = 1'b0;
    end else if (load) begin
      pd_data_d    = data_in;
      pd_dp_d      = dp_in;
      pd_en_d      = en_in;
      pend_valid_d = 1'b1;
    end
  end

  // Output function of the current counter and shadow, registered below.
  always_comb begin
    nib    = 4'h0;
    en_bit = 1'b0;
    dp_bit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib    = sh_data_q[4*i +: 4];
        en_bit = sh_en_q[i];
        dp_bit = sh_dp_q[i];
      end
    end
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (q_q >= Q_LIT && en_bit) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == IW'(i)) an_d[i] = 1'b0;
      end
      seg_d = decode(nib);
      dp_d  = ~dp_bit;
    end
    fs_d = started_q && (q_q == '0) && (idx_q == '0);
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the buffers are cleared on reset so a pending or stale word can never light the display.
      q_q          <= '0;
      idx_q        <= '0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_en_q      <= '0;
      pd_data_q    <= '0;
      pd_dp_q      <= '0;
      pd_en_q      <= '0;
      pend_valid_q <= 1'b0;
      started_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      fs_q         <= 1'b0;
    end else begin
      q_q          <= q_d;
      idx_q        <= idx_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_en_q      <= sh_en_d;
      pd_data_q    <= pd_data_d;
      pd_dp_q      <= pd_dp_d;
      pd_en_q      <= pd_en_d;
      pend_valid_q <= pend_valid_d;
      started_q    <= started_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      fs_q         <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised bench for seg7_scan_driver: a frame-position model predicts every
// output cycle, and literal checks pin the decode, blanking and timing.
module tb_seg7_scan_driver;

  localparam int D  = 4;
  localparam int T  = 8;
  localparam int B  = 2;
  localparam int FR = D * T;

  logic         clk = 1'b0;
  logic         reset, load;
  logic [15:0]  data_in;
  logic [3:0]   dp_in, en_in;
  logic [3:0]   an;
  logic [6:0]   seg;
  logic         dp, frame_start;

  seg7_scan_driver #(.DIGITS(D), .TICK_COUNT(T), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .dp_in(dp_in), .en_in(en_in), .an(an), .seg(seg), .dp(dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: cycles since release give frame position; shadow/pending as plain words.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         m = 0;
  logic [15:0] sh_data = '0, pd_data = '0;
  logic [3:0]  sh_dp = '0, sh_en = '0, pd_dp = '0, pd_en = '0;
  logic        pv = 1'b0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp = 1'b1, exp_fs = 1'b0, exp_valid = 1'b0;

  always @(posedge clk) begin
    int p, d, q;
    if (!reset) begin
      m = 0; sh_data = '0; sh_dp = '0; sh_en = '0; pv = 1'b0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
    end else begin
      p = m % FR; d = p / T; q = p % T;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      if (q >= B && sh_en[d]) begin
        exp_an[d] = 1'b0;
        exp_seg   = seg_tab[sh_data[4*d +: 4]];
        exp_dp    = ~sh_dp[d];
      end
      exp_fs = (p == 0) && (m >= FR);
      if (p == FR - 1) begin
        if (load) begin
          sh_data = data_in; sh_dp = dp_in; sh_en = en_in;
        end else if (pv) begin
          sh_data = pd_data; sh_dp = pd_dp; sh_en = pd_en;
        end
        pv = 1'b0;
      end else if (load) begin
        pd_data = data_in; pd_dp = dp_in; pd_en = en_in; pv = 1'b1;
      end
      m++;
    end
    exp_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      check("an", 32'(an), 32'(exp_an));
      check("seg", 32'(seg), 32'(exp_seg));
      check("dp", 32'(dp), 32'(exp_dp));
      check("frame_start", 32'(frame_start), 32'(exp_fs));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 200);
    if (!frame_start) check("fs_timeout", 32'(frame_start), 32'd1);
  endtask

  task automatic wait_phase(input int ph);
    int k = 0;
    while ((m % FR) != ph && k < 100) begin
      @(negedge clk);
      k++;
    end
    if ((m % FR) != ph) check("phase_timeout", 32'(m % FR), 32'(ph));
  endtask

  task automatic do_load(input logic [15:0] dat, input logic [3:0] dps, input logic [3:0] ens);
    data_in = dat; dp_in = dps; en_in = ens; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int k;
    reset = 1'b0; load = 1'b0; data_in = '0; dp_in = '0; en_in = '0;
    step(3);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_fs", 32'(frame_start), 32'd0);
    reset = 1'b1;

    // Dark display: first pulse 33 cycles after release, then every 32.
    wait_fs(k);
    check("first_fs_delay", 32'(k), 32'd33);
    wait_fs(k);
    check("fs_period", 32'(k), 32'd32);

    // Mixed digits with one decimal point.
    wait_phase(5);
    do_load(16'h1280, 4'b0100, 4'hF);
    wait_fs(k);
    step(2);
    check("s0_an", 32'(an), 32'hE);  check("s0_seg", 32'(seg), 32'h40); check("s0_dp", 32'(dp), 32'd1);
    step(8);
    check("s1_an", 32'(an), 32'hD);  check("s1_seg", 32'(seg), 32'h00);
    step(8);
    check("s2_an", 32'(an), 32'hB);  check("s2_seg", 32'(seg), 32'h24); check("s2_dp", 32'(dp), 32'd0);
    step(8);
    check("s3_an", 32'(an), 32'h7);  check("s3_seg", 32'(seg), 32'h79);

    // Last write wins within a frame.
    wait_phase(2);
    do_load(16'hAAAA, 4'h0, 4'hF);
    wait_phase(6);
    do_load(16'hFFFF, 4'h0, 4'hF);
    wait_fs(k);
    step(2);
    check("lww_seg", 32'(seg), 32'h0E);

    // Load exactly on the frame-end cycle bypasses pending.
    wait_phase(FR - 1);
    do_load(16'h3333, 4'h0, 4'hF);
    wait_fs(k);
    check("fe_load_fs_lat", 32'(k), 32'd1);
    step(2);
    check("fe_load_seg", 32'(seg), 32'h30);

    // Disabled digits stay dark for their whole slot.
    wait_phase(3);
    do_load(16'h5A7C, 4'hF, 4'b0101);
    wait_fs(k);
    step(8);
    for (int i = 0; i < T; i++) begin
      check("dis_an", 32'(an), 32'hF);
      check("dis_seg", 32'(seg), 32'h7F);
      check("dis_dp", 32'(dp), 32'd1);
      step(1);
    end

    // Random loads at random phases.
    for (int i = 0; i < 800; i++) begin
      data_in = 16'($urandom);
      dp_in   = 4'($urandom);
      en_in   = 4'($urandom);
      load    = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    load = 1'b0;

    // Reset mid-slot with a load pending: all state discarded.
    wait_phase(10);
    do_load(16'h8888, 4'hF, 4'hF);
    reset = 1'b0;
    step(1);
    check("abort_an", 32'(an), 32'hF);
    check("abort_seg", 32'(seg), 32'h7F);
    check("abort_dp", 32'(dp), 32'd1);
    step(2);
    reset = 1'b1;
    step(80);
    check("post_abort_an", 32'(an), 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
